// File: rtl/key_evt_if.sv
// key_evt_if: valid/ready key event stream between scanner (master) and consumer (slave)
//   valid  event available          ready  consumer accepts
//   id     channel of the event     press  1 = press, 0 = release
//   level  channel value at the confirming tick
interface key_evt_if;
  logic        valid;
  logic        ready;
  logic [2:0]  id;
  logic        press;
  logic [11:0] level;
  modport master (output valid, id, press, level, input ready);
  modport slave  (input valid, id, press, level, output ready);
endinterface

// File: rtl/adc_key_scanner.sv
// adc_key_scanner: debounced 8-key scanner with hysteresis, emits press/release events on a stream
//   clk, rst_n   clock, asynchronous active-low reset
//   ch0..ch7     12-bit channel values, sampled on prescaler ticks only
//   keys         debounced key state, bit i = channel i pressed
//   overrun      sticky per channel: a pending event was overwritten
//   evt          key event stream (master side)
//   ADC_KEY_LEVEL_EN: when defined, evt.level carries the latched channel value; else 12'd0
module adc_key_scanner #(
  parameter int          SAMPLE_DIV = 50000,
  parameter logic [11:0] TH_PRESS   = 12'd2500,
  parameter logic [11:0] TH_RELEASE = 12'd1500,
  parameter int          DEBOUNCE   = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [11:0]      ch0, ch1, ch2, ch3, ch4, ch5, ch6, ch7,
  output logic [7:0]       keys,
  output logic [7:0]       overrun,
  key_evt_if.master        evt
);
  localparam int PW = (SAMPLE_DIV > 2) ? $clog2(SAMPLE_DIV) : 1;
  localparam int CW = $clog2(DEBOUNCE + 1);
  localparam logic [CW-1:0] DB_LAST = CW'(DEBOUNCE - 1);
  typedef enum logic {IDLE, OUT} state_t;
  state_t        state;
  logic [PW-1:0] pre;
  logic          tick;
  logic [11:0]   ch [8];
  logic [CW-1:0] cnt [8];
  logic [7:0]    pending, pend_press, qual, toggle;
  logic [2:0]    rr, pick, j;
  logic          found, load;
`ifdef ADC_KEY_LEVEL_EN
  logic [11:0]   pend_level [8];
`else
  assign evt.level = 12'd0;
`endif
  assign ch = '{ch0, ch1, ch2, ch3, ch4, ch5, ch6, ch7};
  assign tick = pre == PW'(SAMPLE_DIV - 1);
  assign load = state == IDLE && found;
  always_comb begin
    qual = '0;
    toggle = '0;
    for (int i = 0; i < 8; i++) begin
      qual[i] = keys[i] ? ch[i] <= TH_RELEASE : ch[i] >= TH_PRESS;
      toggle[i] = tick && qual[i] && cnt[i] == DB_LAST;
    end
  end
  // Scan offsets downward so the nearest set bit at or after rr wins.
  always_comb begin
    found = 1'b0;
    pick = rr;
    j = '0;
    for (int k = 7; k >= 0; k--) begin
      j = rr + 3'(k);
      if (pending[j]) begin
        found = 1'b1;
        pick = j;
      end
    end
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      pre <= '0;
      keys <= '0;
      overrun <= '0;
      pending <= '0;
      pend_press <= '0;
      state <= IDLE;
      rr <= '0;
      evt.valid <= 1'b0;
      evt.id <= '0;
      evt.press <= 1'b0;
      for (int i = 0; i < 8; i++) cnt[i] <= '0;
`ifdef ADC_KEY_LEVEL_EN
      evt.level <= '0;
      for (int i = 0; i < 8; i++) pend_level[i] <= '0;
`endif
    end else begin
      pre <= tick ? '0 : pre + 1'b1;
      if (load) begin
        state <= OUT;
        evt.valid <= 1'b1;
        evt.id <= pick;
        evt.press <= pend_press[pick];
        pending[pick] <= 1'b0;
`ifdef ADC_KEY_LEVEL_EN
        evt.level <= pend_level[pick];
`endif
      end else if (state == OUT && evt.ready) begin
        state <= IDLE;
        evt.valid <= 1'b0;
        rr <= evt.id + 3'd1;
      end
      // A toggle overrides a same-cycle load clear; that load already took the old event,
      // so it is not counted as an overrun.
      for (int i = 0; i < 8; i++)
        if (toggle[i]) begin
          keys[i] <= ~keys[i];
          cnt[i] <= '0;
          pending[i] <= 1'b1;
          pend_press[i] <= ~keys[i];
          if (pending[i] && !(load && pick == 3'(i))) overrun[i] <= 1'b1;
`ifdef ADC_KEY_LEVEL_EN
          pend_level[i] <= ch[i];
`endif
        end else if (tick)
          cnt[i] <= qual[i] ? cnt[i] + 1'b1 : '0;
    end
endmodule

// File: tb/tb_adc_key_scanner.sv
// tb_adc_key_scanner: directed self-checking bench for adc_key_scanner (SAMPLE_DIV=4, DEBOUNCE=3)
module tb_adc_key_scanner;
  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [11:0] ch [8];
  logic [7:0]  keys, overrun;
  int          vectors = 0;
  int          errs = 0;
  int          cyc = 0;
  key_evt_if evt();
  adc_key_scanner #(.SAMPLE_DIV(4), .DEBOUNCE(3)) dut (
    .clk(clk), .rst_n(rst_n),
    .ch0(ch[0]), .ch1(ch[1]), .ch2(ch[2]), .ch3(ch[3]),
    .ch4(ch[4]), .ch5(ch[5]), .ch6(ch[6]), .ch7(ch[7]),
    .keys(keys), .overrun(overrun), .evt(evt)
  );
  always #5 clk = ~clk;
  function automatic logic [11:0] lv(input logic [11:0] v);
`ifdef ADC_KEY_LEVEL_EN
    return v;
`else
    return 12'd0;
`endif
  endfunction
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      errs++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask
  task automatic step();
    @(posedge clk);
    cyc++;
    #1;
  endtask
  // Prescaler restarts at reset release, so every 4th edge afterwards samples the channels.
  task automatic tick_edge(input int n);
    for (int t = 0; t < n; t++) begin
      do step(); while (cyc % 4 != 0);
    end
  endtask
  task automatic take(input string tag, input logic [2:0] id, input logic pr, input logic [11:0] v);
    int n = 0;
    while (!evt.valid && n < 20) begin
      step();
      n++;
    end
    chk({tag, "_valid"}, 32'(evt.valid), 32'd1);
    chk({tag, "_id"}, 32'(evt.id), 32'(id));
    chk({tag, "_press"}, 32'(evt.press), 32'(pr));
    chk({tag, "_level"}, 32'(evt.level), 32'(lv(v)));
    evt.ready = 1'b1;
    step();
    evt.ready = 1'b0;
    chk({tag, "_gap"}, 32'(evt.valid), 32'd0);
  endtask
  initial begin
    evt.ready = 1'b0;
    for (int i = 0; i < 8; i++) ch[i] = 12'd0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_keys", 32'(keys), 32'h0);
    chk("rst_valid", 32'(evt.valid), 32'd0);
    chk("rst_id", 32'(evt.id), 32'd0);
    chk("rst_level", 32'(evt.level), 32'd0);
    rst_n = 1'b1;
    cyc = 0;
    // Press on CH2 after three qualifying ticks, VALID one cycle later.
    ch[2] = 12'd3000;
    tick_edge(2);
    chk("p2_early", 32'(keys), 32'h0);
    tick_edge(1);
    chk("p2_keys", 32'(keys), 32'h04);
    chk("p2_lat0", 32'(evt.valid), 32'd0);
    step();
    chk("p2_lat1", 32'(evt.valid), 32'd1);
    take("p2", 3'd2, 1'b1, 12'd3000);
    // Hysteresis: a 2000 sample breaks the run on CH4.
    ch[4] = 12'd3000;
    tick_edge(2);
    ch[4] = 12'd2000;
    tick_edge(1);
    ch[4] = 12'd3000;
    tick_edge(2);
    ch[4] = 12'd0;
    chk("hyst_keys", 32'(keys), 32'h04);
    chk("hyst_valid", 32'(evt.valid), 32'd0);
    // CH5 press, then 2000 never releases, 1000 does.
    ch[5] = 12'd3000;
    tick_edge(3);
    take("p5", 3'd5, 1'b1, 12'd3000);
    ch[5] = 12'd2000;
    tick_edge(5);
    chk("r5_hold", 32'(keys), 32'h24);
    ch[5] = 12'd1000;
    tick_edge(3);
    chk("r5_keys", 32'(keys), 32'h04);
    take("r5", 3'd5, 1'b0, 12'd1000);
    // rr = 6: simultaneous CH0/CH3/CH7 presses come out 7,0,3.
    ch[0] = 12'd3000; ch[3] = 12'd3000; ch[7] = 12'd3000;
    tick_edge(3);
    chk("g1_keys", 32'(keys), 32'h8D);
    take("g1a", 3'd7, 1'b1, 12'd3000);
    take("g1b", 3'd0, 1'b1, 12'd3000);
    take("g1c", 3'd3, 1'b1, 12'd3000);
    // rr = 4: releases also come out 7,0,3.
    ch[0] = 12'd1000; ch[3] = 12'd1000; ch[7] = 12'd1000;
    tick_edge(3);
    chk("g2_keys", 32'(keys), 32'h04);
    take("g2a", 3'd7, 1'b0, 12'd1000);
    take("g2b", 3'd0, 1'b0, 12'd1000);
    take("g2c", 3'd3, 1'b0, 12'd1000);
    ch[7] = 12'd3000;
    tick_edge(3);
    take("p7", 3'd7, 1'b1, 12'd3000);
    // rr = 0: order 0,3,7.
    ch[0] = 12'd3000; ch[3] = 12'd3000; ch[7] = 12'd1000;
    tick_edge(3);
    chk("g3_keys", 32'(keys), 32'h0D);
    take("g3a", 3'd0, 1'b1, 12'd3000);
    take("g3b", 3'd3, 1'b1, 12'd3000);
    take("g3c", 3'd7, 1'b0, 12'd1000);
    // Back-pressure on CH1: loaded event stays stable; overrun only on third toggle.
    ch[1] = 12'd3000;
    tick_edge(3);
    step();
    chk("bp_valid", 32'(evt.valid), 32'd1);
    ch[1] = 12'd1000;
    tick_edge(3);
    chk("bp_keys1", 32'(keys), 32'h0D);
    chk("bp_id", 32'(evt.id), 32'd1);
    chk("bp_press", 32'(evt.press), 32'd1);
    chk("bp_no_ovr", 32'(overrun), 32'h00);
    ch[1] = 12'd3000;
    repeat (6) step();
    tick_edge(3);
    chk("bp_keys2", 32'(keys), 32'h0F);
    chk("bp_ovr", 32'(overrun), 32'h02);
    take("bp_first", 3'd1, 1'b1, 12'd3000);
    take("bp_second", 3'd1, 1'b1, 12'd3000);
    // Fill every pending bit while an event is held, then reset.
    for (int i = 0; i < 8; i++) ch[i] = (i < 4) ? 12'd1000 : 12'd3000;
    tick_edge(3);
    chk("all_keys1", 32'(keys), 32'hF0);
    step();
    chk("all_id", 32'(evt.id), 32'd2);
    chk("all_press", 32'(evt.press), 32'd0);
    for (int i = 0; i < 8; i++) ch[i] = (i < 4) ? 12'd3000 : 12'd1000;
    tick_edge(3);
    chk("all_keys2", 32'(keys), 32'h0F);
    chk("all_valid", 32'(evt.valid), 32'd1);
    chk("all_ovr", 32'(overrun), 32'hFB);
    rst_n = 1'b0;
    #1;
    chk("arst_valid", 32'(evt.valid), 32'd0);
    chk("arst_keys", 32'(keys), 32'h0);
    chk("arst_ovr", 32'(overrun), 32'h0);
    for (int i = 0; i < 8; i++) ch[i] = 12'd0;
    step();
    rst_n = 1'b1;
    cyc = 0;
    repeat (20) step();
    chk("post_valid", 32'(evt.valid), 32'd0);
    chk("post_keys", 32'(keys), 32'h0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errs);
    $finish;
  end
endmodule
